// File: rtl/usbls_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usbls_tx_pkg
//  Purpose  : Shared USB low-speed constants (PIDs, SYNC, line states, CRC16)
//             and the transmit FSM state type. Used by the transmitter and
//             intended to be shared with the bus receiver.
//  Revision : 1.0  initial release
// ============================================================================
package usbls_tx_pkg;

    // PID codes (low nibble; the wire byte is {~PID, PID})
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    // SYNC byte, sent LSB first -> KJKJKJKK after NRZI
    localparam logic [7:0] SYNC_BYTE = 8'b1000_0000;

    // Low-speed line states as {dp, dn}
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // CRC16 x^16+x^15+x^2+1, processed LSB first (reflected form)
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PID  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_SE0  = 3'd5,
        ST_EOPJ = 3'd6
    } tx_state_e;

    // Only DATA0/DATA1 carry a payload and CRC
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    // One serial CRC16 step for an LSB-first bit stream
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {1'b0, crc[15:1]};
        return (crc[0] ^ din) ? (shifted ^ CRC16_POLY_REFL) : shifted;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usbls_crc16.sv
`default_nettype none
// ============================================================================
//  Module   : usbls_crc16
//  Purpose  : Serial USB CRC16 register. init loads FFFF, en shifts in din.
//             The raw register is exposed; the caller inverts it for sending
//             or compares it against the residue when checking.
//  Revision : 1.0  initial release
// ============================================================================
module usbls_crc16
    import usbls_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: init has priority over a data step
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, din);
        end
    end

    // CRC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/usbls_tx_top.sv
`default_nettype none
// ============================================================================
//  Module   : usbls_tx_top
//  Purpose  : USB 1.0 low-speed packet transmitter. Serialises SYNC, PID,
//             optional payload and CRC16, bit-stuffs, NRZI-encodes, appends
//             EOP and drives the D+/D- pads with output enables.
//  Revision : 1.0  initial release
// ============================================================================
module usbls_tx_top
    import usbls_tx_pkg::*;
#(
    parameter int MAX_BYTES = 8,
    parameter int EOP_SE0   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [3:0]  tx_pid,
    input  logic [63:0] tx_data,
    input  logic [3:0]  byte_size,
    output logic        dp_OUT,
    output logic        dn_OUT,
    output logic        dp_OE,
    output logic        dn_OE,
    output logic        tx_busy,
    output logic        tx_done
);

    // State of the bit currently on the line. During a stuffed cycle the
    // pointer (state/cnt) still names the last data bit sent.
    tx_state_e   state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;     // bit index within the current field
    logic        stuff_q, stuff_d;   // current line bit is a stuffed 0
    logic [2:0]  ones_q,  ones_d;    // consecutive 1s before the current bit
    logic        line_q,  line_d;    // NRZI level of the previous bit (1 = J)
    logic [3:0]  pid_q,   pid_d;
    logic [63:0] data_q,  data_d;    // payload; current byte is [63:56]
    logic [3:0]  n_q,     n_d;       // clamped payload byte count
    logic        done_q,  done_d;

    logic        w_crc_init;
    logic        w_crc_en;
    logic [15:0] w_crc;
    logic [7:0]  w_pid_byte;
    logic [7:0]  w_cur_byte;
    logic        w_bit_state;
    logic        w_raw;
    logic        w_bit;
    logic        w_level;
    logic [2:0]  w_ones;
    logic        w_stuff_next;
    logic [6:0]  w_last_data;
    logic [3:0]  w_size_clamped;

    assign w_pid_byte     = {~pid_q, pid_q};
    assign w_cur_byte     = data_q[63:56];
    assign w_last_data    = {n_q, 3'b000} - 7'd1;
    assign w_size_clamped = (32'(byte_size) > MAX_BYTES) ? 4'(MAX_BYTES) : byte_size;
    assign w_bit_state    = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                            (state_q == ST_DATA) || (state_q == ST_CRC);

    // Raw (unstuffed) bit selected by the field pointer
    always_comb begin
        w_raw = 1'b0;
        unique case (state_q)
            ST_SYNC: w_raw = SYNC_BYTE[cnt_q[2:0]];
            ST_PID:  w_raw = w_pid_byte[cnt_q[2:0]];
            ST_DATA: w_raw = w_cur_byte[cnt_q[2:0]];
            ST_CRC:  w_raw = ~w_crc[cnt_q[3:0]];
            default: w_raw = 1'b0;
        endcase
    end

    // A stuffed cycle always sends 0; NRZI toggles on 0 and holds on 1
    assign w_bit        = w_raw & ~stuff_q;
    assign w_level      = w_bit ? line_q : ~line_q;
    assign w_ones       = w_bit ? 3'(ones_q + 3'd1) : 3'd0;
    assign w_stuff_next = w_bit_state && (w_ones == 3'd6);

    // Payload bits feed the CRC as they go out; stuffed bits do not
    assign w_crc_en = (state_q == ST_DATA) && !stuff_q;

    usbls_crc16 u_crc16 (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_crc_init),
        .en    (w_crc_en),
        .din   (w_raw),
        .crc   (w_crc)
    );

    // Next-state logic: field sequencing, stuff insertion, NRZI and latching
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stuff_d    = 1'b0;
        ones_d     = ones_q;
        line_d     = line_q;
        pid_d      = pid_q;
        data_d     = data_q;
        n_d        = n_q;
        done_d     = 1'b0;
        w_crc_init = 1'b0;

        if (w_bit_state) begin
            line_d = w_level;
            ones_d = w_ones;
        end

        // Move to the next payload byte once its MSB has gone out
        if (w_crc_en && (cnt_q[2:0] == 3'd7)) begin
            data_d = {data_q[55:0], 8'h00};
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    pid_d      = tx_pid;
                    data_d     = tx_data;
                    n_d        = w_size_clamped;
                    state_d    = ST_SYNC;
                    cnt_d      = 6'd0;
                    line_d     = 1'b1;
                    ones_d     = 3'd0;
                    w_crc_init = 1'b1;
                end
            end
            ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
                if (w_stuff_next) begin
                    stuff_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (state_q == ST_SYNC && cnt_q == 6'd7) begin
                        state_d = ST_PID;
                        cnt_d   = 6'd0;
                    end else if (state_q == ST_PID && cnt_q == 6'd7) begin
                        cnt_d = 6'd0;
                        if (!is_data_pid(pid_q)) begin
                            state_d = ST_SE0;
                        end else if (n_q == 4'd0) begin
                            state_d = ST_CRC;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else if (state_q == ST_DATA && {1'b0, cnt_q} == w_last_data) begin
                        state_d = ST_CRC;
                        cnt_d   = 6'd0;
                    end else if (state_q == ST_CRC && cnt_q == 6'd15) begin
                        state_d = ST_SE0;
                        cnt_d   = 6'd0;
                    end
                end
            end
            ST_SE0: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(EOP_SE0 - 1)) begin
                    state_d = ST_EOPJ;
                    cnt_d   = 6'd0;
                end
            end
            ST_EOPJ: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            stuff_q <= 1'b0;
            ones_q  <= 3'd0;
            line_q  <= 1'b1;
            pid_q   <= 4'd0;
            data_q  <= 64'd0;
            n_q     <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stuff_q <= stuff_d;
            ones_q  <= ones_d;
            line_q  <= line_d;
            pid_q   <= pid_d;
            data_q  <= data_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end

    // Pad drive decoded from the registered state; idle and reset rest at J
    always_comb begin
        {dp_OUT, dn_OUT} = LINE_J;
        dp_OE            = 1'b0;
        unique case (state_q)
            ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
                dp_OE            = 1'b1;
                {dp_OUT, dn_OUT} = w_level ? LINE_J : LINE_K;
            end
            ST_SE0: begin
                dp_OE            = 1'b1;
                {dp_OUT, dn_OUT} = LINE_SE0;
            end
            ST_EOPJ: begin
                dp_OE            = 1'b1;
                {dp_OUT, dn_OUT} = LINE_J;
            end
            default: begin
                dp_OE            = 1'b0;
                {dp_OUT, dn_OUT} = LINE_J;
            end
        endcase
    end

    assign dn_OE   = dp_OE;
    assign tx_busy = (state_q != ST_IDLE);
    assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_usbls_tx_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usbls_tx_top
//  Purpose  : Self-checking bench for usbls_tx_top. Expected line symbols are
//             built from the packet rules and queued at issue; a monitor pops
//             and compares every cycle the transmitter is expected to drive.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usbls_tx_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [3:0]  tx_pid = 4'd0;
    logic [63:0] tx_data = 64'd0;
    logic [3:0]  byte_size = 4'd0;
    logic        dp_OUT, dn_OUT, dp_OE, dn_OE, tx_busy, tx_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q[$];   // expected {dp,dn} per driven cycle
    bit         prev_active = 1'b0;
    bit         mon_act;
    logic [1:0] mon_e;

    usbls_tx_top #(.MAX_BYTES(8), .EOP_SE0(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_start  (tx_start),
        .tx_pid    (tx_pid),
        .tx_data   (tx_data),
        .byte_size (byte_size),
        .dp_OUT    (dp_OUT),
        .dn_OUT    (dn_OUT),
        .dp_OE     (dp_OE),
        .dn_OE     (dn_OE),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: raw bit list -> stuffing -> NRZI symbols -> EOP
    task automatic push_packet(input logic [3:0] pid, input logic [63:0] data, input logic [3:0] bs);
        bit          raw[$];
        bit          st[$];
        logic [7:0]  sync_b = 8'h80;
        logic [7:0]  pid_b;
        logic [15:0] crc;
        int          n, ones;
        bit          lvl, d;
        pid_b = {~pid, pid};
        for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
        for (int i = 0; i < 8; i++) raw.push_back(pid_b[i]);
        if (pid == 4'b0011 || pid == 4'b1011) begin
            n   = (bs > 8) ? 8 : int'(bs);
            crc = 16'hFFFF;
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < 8; i++) begin
                    d = data[56 - 8*b + i];
                    raw.push_back(d);
                    if (crc[0] ^ d) crc = (crc >> 1) ^ 16'hA001;
                    else            crc = crc >> 1;
                end
            end
            for (int i = 0; i < 16; i++) raw.push_back(~crc[i]);
        end
        ones = 0;
        foreach (raw[k]) begin
            st.push_back(raw[k]);
            ones = raw[k] ? ones + 1 : 0;
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (st[k]) begin
            if (!st[k]) lvl = ~lvl;
            exp_q.push_back(lvl ? 2'b01 : 2'b10);
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
    endtask

    // Wait until every expected symbol has been seen, bounded
    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_checks++;
            $display("FAIL idle_timeout: got %0d symbols left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Issue one packet; optionally pulse a conflicting tx_start mid-packet
    task automatic send(input logic [3:0] pid, input logic [63:0] data, input logic [3:0] bs,
                        input int gap, input int glitch_at);
        wait_idle();
        repeat (gap) @(posedge clk);
        #1;
        tx_start  = 1'b1;
        tx_pid    = pid;
        tx_data   = data;
        byte_size = bs;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        push_packet(pid, data, bs);
        if (glitch_at > 0) begin
            repeat (glitch_at) @(negedge clk);
            #1;
            tx_start  = 1'b1;
            tx_pid    = ~pid;
            tx_data   = {$urandom, $urandom};
            byte_size = 4'd8;
            @(negedge clk);
            #1;
            tx_start = 1'b0;
        end
    endtask

    // Monitor: per-cycle comparison of pads, enables, busy and done
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_active = 1'b0;
        end else begin
            mon_act = (exp_q.size() > 0);
            check("dp_oe", dp_OE, mon_act);
            check("dn_oe", dn_OE, mon_act);
            check("busy", tx_busy, mon_act);
            check("done", tx_done, prev_active && !mon_act);
            if (mon_act) begin
                mon_e = exp_q.pop_front();
                check("line", {dp_OUT, dn_OUT}, mon_e);
            end else begin
                check("idle_line", {dp_OUT, dn_OUT}, 2'b01);
            end
            prev_active = mon_act;
        end
    end

    initial begin
        logic [3:0] rpid;
        #12;
        check("rst_oe", {dp_OE, dn_OE}, 2'b00);
        check("rst_line", {dp_OUT, dn_OUT}, 2'b01);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        send(4'b0010, 64'd0, 4'd0, 1, 0);                       // ACK
        send(4'b1010, 64'd0, 4'd0, 0, 0);                       // NAK, back-to-back
        send(4'b0011, 64'hDEAD_BEEF_0000_0000, 4'd0, 2, 0);      // DATA0, empty
        send(4'b1011, 64'hFF00_0000_0000_0000, 4'd1, 0, 0);      // DATA1, one 0xFF
        send(4'b0011, 64'h0123_4567_89AB_CDEF, 4'd8, 1, 0);      // DATA0, 8 bytes
        send(4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 0, 0);     // clamp to 8, heavy stuffing
        send(4'b0010, 64'd0, 4'd0, 0, 5);                       // start ignored mid-packet
        send(4'b0011, 64'h0F0F_F0F0_1234_5678, 4'd3, 0, 20);

        // Reset during DATA
        send(4'b0011, {$urandom, $urandom}, 4'd8, 0, 0);
        repeat (28) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", {dp_OE, dn_OE}, 2'b00);
        check("mid_rst_line", {dp_OUT, dn_OUT}, 2'b01);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_done", tx_done, 1'b0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        send(4'b1011, 64'hA5A5_5A5A_C3C3_3C3C, 4'd5, 1, 0);

        // Randomized packets
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 4))
                0:       rpid = 4'b0011;
                1:       rpid = 4'b1011;
                2:       rpid = 4'b0010;
                3:       rpid = 4'b1010;
                default: rpid = 4'($urandom);
            endcase
            send(rpid, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0);
        end

        wait_idle();
        repeat (4) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
